// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV64 pipeline: turns M-stage load/store control into a
// single-outstanding req/ack transaction and presents aligned/extended results to W.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] M_pc_i,
  input  logic [63:0] M_alu_result_i,
  input  logic [63:0] M_store_data_i,
  input  logic        M_mem_ren_i,
  input  logic        M_mem_wen_i,
  input  logic [2:0]  M_funct3_i,
  input  logic        M_reg_wen_i,
  input  logic        M_reg_mux_i,
  input  logic [4:0]  M_reg_waddr_i,
  input  logic        ctrl_stall_i,
  output logic [63:0] W_pc_o,
  output logic [63:0] W_alu_result_o,
  output logic [63:0] W_mem_rdata_o,
  output logic        W_reg_wen_o,
  output logic        W_reg_mux_o,
  output logic [4:0]  W_reg_waddr_o,
  output logic        mem_stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wstrb_o,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [2:0]  lsb_reg;
  logic [2:0]  funct3_reg;
  logic        load_reg;

  logic        access;
  logic        misalign;
  logic        start;
  logic        timeout;
  logic [2:0]  lsb;
  logic [7:0]  strb_base;

  assign lsb    = M_alu_result_i[2:0];
  assign access = M_mem_ren_i | M_mem_wen_i;

  always_comb begin
    misalign  = 1'b0;
    strb_base = 8'h01;
    case (M_funct3_i[1:0])
      2'd1: begin misalign = lsb[0];      strb_base = 8'h03; end
      2'd2: begin misalign = |lsb[1:0];   strb_base = 8'h0F; end
      2'd3: begin misalign = |lsb;        strb_base = 8'hFF; end
      default: begin misalign = 1'b0;     strb_base = 8'h01; end
    endcase
  end

  assign misalign_o = access & misalign;
  assign start      = access & ~misalign;
  // Ack takes priority over an expiring counter in the same cycle.
  assign timeout    = (state_reg == BUSY) & ~dmem_ack_i & (cnt_reg == TIMEOUT_LAST);

  function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                              input logic [2:0]  offs,
                                              input logic [2:0]  f3);
    logic [63:0] lane;
    logic [63:0] res;
    lane = rdata >> {offs, 3'b000};
    case (f3)
      3'b000:  res = {{56{lane[7]}},  lane[7:0]};
      3'b001:  res = {{48{lane[15]}}, lane[15:0]};
      3'b010:  res = {{32{lane[31]}}, lane[31:0]};
      3'b100:  res = {56'd0, lane[7:0]};
      3'b101:  res = {48'd0, lane[15:0]};
      3'b110:  res = {32'd0, lane[31:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_stall_o = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          mem_stall_o = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        mem_stall_o = 1'b1;
        if (dmem_ack_i || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!ctrl_stall_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 64'd0;
      dmem_wdata_o  <= 64'd0;
      dmem_wstrb_o  <= 8'd0;
      W_mem_rdata_o <= 64'd0;
      bus_err_o     <= 1'b0;
      cnt_reg       <= 16'd0;
      lsb_reg       <= 3'd0;
      funct3_reg    <= 3'd0;
      load_reg      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= M_mem_wen_i;
            dmem_addr_o  <= {M_alu_result_i[63:3], 3'b000};
            dmem_wdata_o <= M_mem_wen_i ? (M_store_data_i << {lsb, 3'b000}) : 64'd0;
            dmem_wstrb_o <= M_mem_wen_i ? 8'(strb_base << lsb) : 8'd0;
            cnt_reg      <= 16'd0;
            lsb_reg      <= lsb;
            funct3_reg   <= M_funct3_i;
            load_reg     <= M_mem_ren_i;
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (load_reg) begin
              W_mem_rdata_o <= load_extend(dmem_rdata_i, lsb_reg, funct3_reg);
            end
          end else if (timeout) begin
            dmem_req_o    <= 1'b0;
            W_mem_rdata_o <= 64'd0;
            bus_err_o     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        DONE: begin
          if (!ctrl_stall_i) begin
            bus_err_o <= 1'b0;
          end
        end
        default: begin
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign W_pc_o         = M_pc_i;
  assign W_alu_result_o = M_alu_result_i;
  assign W_reg_mux_o    = M_reg_mux_i;
  assign W_reg_waddr_o  = M_reg_waddr_i;
  // A faulted or misaligned access must not write the register file.
  assign W_reg_wen_o    = M_reg_wen_i & ~misalign_o & ~bus_err_o;

endmodule
